rsa256_wrapper: RTL and testbench

- Control front end that drives the RSA256 decryption core from an RS232 UART peripheral over an Avalon-MM master port.
- Polls UART status, then reads 32 bytes of modulus n, 32 bytes of private key d, and 32 bytes of ciphertext a.
- Pulses the core start, waits for core finished, then writes 31 plaintext bytes back to UART TX.
- Keeps n and d, then loops to receive the next ciphertext. It is the initiator side of the core's start/finished handshake.

---
 rtl/rsa_wrapper_pkg.sv | 45 ++++
 rtl/rsa256_wrapper.sv | 148 ++++++++++++++
 tb/tb_rsa256_wrapper.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_wrapper_pkg.sv
// Shared types and constants for the RSA256 UART front end.
package rsa_wrapper_pkg;

   // UART peripheral register map (word addresses on the Avalon bus)
   localparam logic [4:0] RX_BASE     = 5'd0;
   localparam logic [4:0] TX_BASE     = 5'd4;
   localparam logic [4:0] STATUS_BASE = 5'd8;

   // Status register flag positions
   localparam int RX_OK_BIT = 7;
   localparam int TX_OK_BIT = 6;

   // Operand and plaintext byte counts
   localparam int IN_BYTES  = 32;
   localparam int OUT_BYTES = 31;

   localparam logic [4:0] IN_LAST  = 5'(IN_BYTES - 1);
   localparam logic [4:0] OUT_LAST = 5'(OUT_BYTES - 1);

   typedef enum logic [2:0] {
      S_QUERY_RX,
      S_READ,
      S_CALC,
      S_WAIT_CALC,
      S_QUERY_TX,
      S_WRITE
   } state_t;

   // Which operand register the incoming bytes are shifted into
   typedef enum logic [1:0] {
      STG_N,
      STG_D,
      STG_A
   } stage_t;

   // Operand order on the wire is n, then d, then a; a repeats afterwards.
   function automatic stage_t next_stage(input stage_t s);
      case (s)
         STG_N:   next_stage = STG_D;
         STG_D:   next_stage = STG_A;
         default: next_stage = STG_A;
      endcase
   endfunction

endpackage

// File: rtl/rsa256_wrapper.sv
// Drives the RSA256 core from a UART peripheral over an Avalon-MM master:
// receives n, d and a byte by byte, runs the core, then sends 31 plaintext
// bytes back. n and d are kept so later messages only need a new a.
//
// Avalon handshake: o_avm_read / o_avm_write and o_avm_address are held
// steady while i_avm_waitrequest is 1; the first cycle with waitrequest 0
// completes the transfer and i_avm_readdata is sampled in that cycle.
module rsa256_wrapper
   import rsa_wrapper_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   output logic [4:0]   o_avm_address,
   output logic         o_avm_read,
   input  logic [31:0]  i_avm_readdata,
   output logic         o_avm_write,
   output logic [31:0]  o_avm_writedata,
   input  logic         i_avm_waitrequest,
   output logic         o_core_start,
   output logic [255:0] o_core_a,
   output logic [255:0] o_core_d,
   output logic [255:0] o_core_n,
   input  logic [255:0] i_core_result,
   input  logic         i_core_finished
);

   state_t         state;
   state_t         state_next;
   stage_t         stage;
   logic [4:0]     cnt;
   logic [255:0]   n_r;
   logic [255:0]   d_r;
   logic [255:0]   a_r;
   // Top result byte is never sent, so only the low 248 bits are kept
   logic [247:0]   result_r;

   logic           xfer_done;
   logic [7:0]     byte_in;
   logic           unused_bits;

   assign xfer_done   = ~i_avm_waitrequest;
   assign byte_in     = i_avm_readdata[7:0];
   assign unused_bits = ^{i_avm_readdata[31:8], i_core_result[255:248]};

   assign o_core_n = n_r;
   assign o_core_d = d_r;
   assign o_core_a = a_r;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_QUERY_RX;
      else       state <= state_next;
   end

   // Next-state: each bus state leaves only on a completed transfer
   always_comb begin
      state_next = state;
      case (state)
         S_QUERY_RX:  if (xfer_done && i_avm_readdata[RX_OK_BIT]) state_next = S_READ;
         S_READ: begin
            if (xfer_done) begin
               if (cnt == IN_LAST && stage == STG_A) state_next = S_CALC;
               else                                  state_next = S_QUERY_RX;
            end
         end
         S_CALC:      state_next = S_WAIT_CALC;
         S_WAIT_CALC: if (i_core_finished) state_next = S_QUERY_TX;
         S_QUERY_TX:  if (xfer_done && i_avm_readdata[TX_OK_BIT]) state_next = S_WRITE;
         S_WRITE: begin
            if (xfer_done) begin
               if (cnt == OUT_LAST) state_next = S_QUERY_RX;
               else                 state_next = S_QUERY_TX;
            end
         end
         default:     state_next = S_QUERY_RX;
      endcase
   end

   // Outputs decoded from the current state only
   always_comb begin
      o_avm_address   = STATUS_BASE;
      o_avm_read      = 1'b0;
      o_avm_write     = 1'b0;
      o_avm_writedata = 32'd0;
      o_core_start    = 1'b0;
      case (state)
         S_QUERY_RX: o_avm_read = 1'b1;
         S_READ: begin
            o_avm_address = RX_BASE;
            o_avm_read    = 1'b1;
         end
         S_CALC:     o_core_start = 1'b1;
         S_QUERY_TX: o_avm_read = 1'b1;
         S_WRITE: begin
            o_avm_address   = TX_BASE;
            o_avm_write     = 1'b1;
            o_avm_writedata = {24'd0, result_r[247:240]};
         end
         default: ;
      endcase
   end

   // Datapath: operand shift-in, result capture and shift-out, byte counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stage    <= STG_N;
         cnt      <= 5'd0;
         n_r      <= '0;
         d_r      <= '0;
         a_r      <= '0;
         result_r <= '0;
      end else begin
         case (state)
            S_READ: begin
               if (xfer_done) begin
                  case (stage)
                     STG_N:   n_r <= {n_r[247:0], byte_in};
                     STG_D:   d_r <= {d_r[247:0], byte_in};
                     default: a_r <= {a_r[247:0], byte_in};
                  endcase
                  if (cnt == IN_LAST) begin
                     cnt   <= 5'd0;
                     stage <= next_stage(stage);
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            S_WAIT_CALC: begin
               if (i_core_finished) result_r <= i_core_result[247:0];
            end
            S_WRITE: begin
               if (xfer_done) begin
                  result_r <= {result_r[239:0], 8'h00};
                  if (cnt == OUT_LAST) begin
                     cnt   <= 5'd0;
                     stage <= STG_A;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa256_wrapper.sv
// Directed bench for rsa256_wrapper: behavioural UART slave, model core,
// and a linear sequence of checks.
module tb_rsa256_wrapper;

   logic         clk;
   logic         rst;
   logic [4:0]   avm_address;
   logic         avm_read;
   logic [31:0]  avm_readdata;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic         avm_waitrequest;
   logic         core_start;
   logic [255:0] core_a;
   logic [255:0] core_d;
   logic [255:0] core_n;
   logic [255:0] core_res;
   logic         core_fin;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   rsa256_wrapper dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .o_avm_address     (avm_address),
      .o_avm_read        (avm_read),
      .i_avm_readdata    (avm_readdata),
      .o_avm_write       (avm_write),
      .o_avm_writedata   (avm_writedata),
      .i_avm_waitrequest (avm_waitrequest),
      .o_core_start      (core_start),
      .o_core_a          (core_a),
      .o_core_d          (core_d),
      .o_core_n          (core_n),
      .i_core_result     (core_res),
      .i_core_finished   (core_fin)
   );

   // ---------------- UART slave model ----------------
   logic [7:0]  rx_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_q[$];
   int          rx_total     = 0;
   int          rx_idx       = 0;
   int          status_reads = 0;
   int          zero_until   = 0;
   int          stall_target = 0;
   int          stall_seen   = 0;
   logic        stall_prev   = 1'b0;
   int          hold_err     = 0;
   int          tx_addr_bad  = 0;
   int          tx_hi_bad    = 0;
   logic        rx_ok;
   logic [7:0]  rx_byte;

   always_comb begin
      rx_ok   = (rx_idx < rx_total) && (status_reads >= zero_until);
      rx_byte = (rx_idx < rx_total) ? rx_q[rx_idx] : 8'h00;
      if (avm_address == 5'd0)      avm_readdata = {24'hA5A5A5, rx_byte};
      else if (avm_address == 5'd8) avm_readdata = {24'h5A5A5A, rx_ok, 1'b1, 6'b010101};
      else                          avm_readdata = 32'hDEADBEEF;
      avm_waitrequest = avm_read && (avm_address == 5'd0) && (stall_seen < stall_target);
   end

   always @(posedge clk) begin
      stall_prev <= avm_waitrequest;
      if (stall_prev && !(avm_read && avm_address == 5'd0)) hold_err <= hold_err + 1;
      if (avm_waitrequest) stall_seen <= stall_seen + 1;
      if (avm_read && !avm_waitrequest) begin
         if (avm_address == 5'd0)      rx_idx <= rx_idx + 1;
         else if (avm_address == 5'd8) status_reads <= status_reads + 1;
      end
      if (avm_write && !avm_waitrequest) begin
         tx_q.push_back(avm_writedata[7:0]);
         if (avm_address != 5'd4)       tx_addr_bad <= tx_addr_bad + 1;
         if (avm_writedata[31:8] != '0) tx_hi_bad <= tx_hi_bad + 1;
      end
   end

   // ---------------- model core: finished 10 cycles after start ----------------
   int start_cycles = 0;
   int core_cnt     = 0;

   always @(posedge clk) begin
      core_fin <= 1'b0;
      if (core_start) begin
         start_cycles <= start_cycles + 1;
         core_cnt     <= 10;
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) core_fin <= 1'b1;
      end
   end

   // ---------------- driver tasks / checker ----------------
   task automatic push_bytes(input logic [7:0] first, input int count);
      for (int i = 0; i < count; i++) begin
         rx_q.push_back(first + 8'(i));
      end
      rx_total = rx_total + count;
   endtask

   task automatic push_expected(input logic [247:0] pt);
      for (int i = 0; i < 31; i++) exp_q.push_back(pt[247 - 8*i -: 8]);
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},  avm_address,   5'd8);
      check({tag, "_read"},  avm_read,      1'b1);
      check({tag, "_write"}, avm_write,     1'b0);
      check({tag, "_wdata"}, avm_writedata, 32'd0);
      check({tag, "_start"}, core_start,    1'b0);
      check({tag, "_n"},     core_n,        256'd0);
      check({tag, "_d"},     core_d,        256'd0);
      check({tag, "_a"},     core_a,        256'd0);
   endtask

   localparam logic [255:0] K1 =
      256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
   localparam logic [255:0] A2 =
      256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;
   localparam logic [255:0] N_JUNK =
      256'h909192939495969798999a9b9c9d9e9fa0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
   localparam logic [255:0] D_PART = 256'hb0b1b2b3b4b5b6b7;

   logic [247:0] pt1;
   logic [247:0] pt2;
   int           s0;
   int           stall_base;

   // ---------------- directed sequence ----------------
   initial begin
      pt1      = "The_plaintext_block_number_0053";
      pt2      = "Second_message_for_the_core_ok!";
      rst      = 1'b1;
      core_res = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // Partial key: 32 bytes of n and 8 bytes of d, then reset mid-load
      rst = 1'b0;
      push_bytes(8'h90, 40);
      for (int k = 0; k < 3000 && rx_idx != 40; k++) @(negedge clk);
      check("partial_rx_count", rx_idx, 40);
      repeat (4) @(negedge clk);
      check("partial_n", core_n, N_JUNK);
      check("partial_d", core_d, D_PART);
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst = 1'b0;

      // Full key + ciphertext; first 5 polls report no data, first read stalls 3 cycles
      s0         = status_reads;
      stall_base = stall_seen;
      push_bytes(8'h01, 32);
      push_bytes(8'h01, 32);
      push_bytes(8'h01, 32);
      core_res     = {8'h00, pt1};
      push_expected(pt1);
      zero_until   = s0 + 5;
      stall_target = stall_base + 3;
      for (int k = 0; k < 3000 && rx_idx == 40; k++) @(negedge clk);
      check("first_rx_count", rx_idx, 41);
      check("polls_before_rx", status_reads - s0, 6);
      check("stall_cycles", stall_seen - stall_base, 3);
      check("stall_hold", hold_err, 0);

      for (int k = 0; k < 5000 && start_cycles == 0; k++) @(negedge clk);
      check("rx_count_at_start", rx_idx, 136);
      check("core_n", core_n, K1);
      check("core_d", core_d, K1);
      check("core_a", core_a, K1);

      // Next ciphertext is already waiting while the plaintext goes out,
      // so both status flags are set during the TX phase
      push_bytes(8'h40, 32);
      repeat (3) @(negedge clk);
      check("start_pulse_width", start_cycles, 1);

      for (int k = 0; k < 5000 && tx_q.size() < 31; k++) @(negedge clk);
      check("rx_idle_during_tx", rx_idx, 136);
      check("tx_count_1", tx_q.size(), 31);
      for (int i = 0; i < 31; i++) check("tx_byte_1", tx_q[i], exp_q.pop_front());
      check("tx_addr_1", tx_addr_bad, 0);
      check("tx_upper_1", tx_hi_bad, 0);

      // Second message reuses n and d
      core_res = {8'h00, pt2};
      push_expected(pt2);
      for (int k = 0; k < 5000 && start_cycles < 2; k++) @(negedge clk);
      check("start_count_2", start_cycles, 2);
      check("rx_count_2", rx_idx, 168);
      check("core_n_kept", core_n, K1);
      check("core_d_kept", core_d, K1);
      check("core_a_new", core_a, A2);

      for (int k = 0; k < 5000 && tx_q.size() < 62; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("tx_count_2", tx_q.size(), 62);
      for (int i = 0; i < 31; i++) check("tx_byte_2", tx_q[31 + i], exp_q.pop_front());
      check("tx_addr_2", tx_addr_bad, 0);
      check("tx_upper_2", tx_hi_bad, 0);
      check("hold_final", hold_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
